// File: rtl/sar_avg_sequencer.sv
// sar_avg_sequencer: paces a SAR converter with periodic start pulses, captures
// each result on the rising edge of end-of-conversion, averages 2^Log2Avg
// captures into a truncated mean and flags conversions that never finish.
module sar_avg_sequencer #(
    parameter int Width         = 6,
    parameter int Log2Avg       = 2,
    parameter int IntervalW     = 8,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [IntervalW-1:0] interval_i,
    input  logic                 eoc_i,
    input  logic [Width-1:0]     result_i,
    output logic                 start_o,
    output logic [Width-1:0]     avg_o,
    output logic                 avg_valid_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int AccW = Width + Log2Avg;
    localparam int CntW = Log2Avg + 1;
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    localparam logic [CntW-1:0]      FULL_CNT = CntW'(2 ** Log2Avg);
    localparam logic [CntW-1:0]      ONE_CNT  = CntW'(1);
    localparam logic [TmoW-1:0]      TMO_LAST = TmoW'(TimeoutCycles - 1);
    localparam logic [TmoW-1:0]      ONE_TMO  = TmoW'(1);
    localparam logic [IntervalW-1:0] ONE_IVL  = IntervalW'(1);
    localparam logic [IntervalW-1:0] MAX_IVL  = {IntervalW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state_r;
    logic                 eoc_q_r;
    logic [AccW-1:0]      acc_r;
    logic [CntW-1:0]      smp_cnt_r;
    logic [IntervalW-1:0] ivl_cnt_r;
    logic [IntervalW-1:0] ivl_len_r;
    logic [TmoW-1:0]      tmo_cnt_r;
    logic                 start_r;
    logic [Width-1:0]     avg_r;
    logic                 avg_valid_r;
    logic                 busy_r;
    logic                 timeout_r;

    logic                 eoc_rise_s;
    logic [IntervalW-1:0] ivl_eff_s;
    logic                 ivl_done_s;
    logic                 avg_full_s;
    logic                 tmo_done_s;
    logic [AccW-1:0]      acc_sum_s;

    // Derived conditions: eoc edge, effective interval (0 means 1), counter limits.
    always_comb begin
        eoc_rise_s = eoc_i & ~eoc_q_r;
        if (interval_i == {IntervalW{1'b0}}) begin
            ivl_eff_s = ONE_IVL;
        end else begin
            ivl_eff_s = interval_i;
        end
        ivl_done_s = (ivl_cnt_r >= (ivl_len_r - ONE_IVL));
        avg_full_s = (smp_cnt_r == FULL_CNT);
        tmo_done_s = (tmo_cnt_r >= TMO_LAST);
        acc_sum_s  = acc_r + AccW'(result_i);
    end

    // Delay eoc by one clock so a level held across START is not seen as a new edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eoc_q_r <= 1'b0;
        end else begin
            eoc_q_r <= eoc_i;
        end
    end

    // Sequencer FSM with accumulator, interval/timeout counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            acc_r       <= {AccW{1'b0}};
            smp_cnt_r   <= {CntW{1'b0}};
            ivl_cnt_r   <= {IntervalW{1'b0}};
            ivl_len_r   <= ONE_IVL;
            tmo_cnt_r   <= {TmoW{1'b0}};
            start_r     <= 1'b0;
            avg_r       <= {Width{1'b0}};
            avg_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            avg_valid_r <= 1'b0;
            // The interval counter measures cycles since START and saturates.
            if (ivl_cnt_r != MAX_IVL) begin
                ivl_cnt_r <= ivl_cnt_r + ONE_IVL;
            end
            case (state_r)
                ST_IDLE: begin
                    acc_r     <= {AccW{1'b0}};
                    smp_cnt_r <= {CntW{1'b0}};
                    if (enable_i) begin
                        state_r <= ST_START;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        timeout_r <= 1'b0;
                    end
                end
                ST_START: begin
                    ivl_len_r <= ivl_eff_s;
                    ivl_cnt_r <= ONE_IVL;
                    tmo_cnt_r <= ONE_TMO;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + ONE_TMO;
                    // A capture in the expiry cycle wins over the timeout.
                    if (eoc_rise_s) begin
                        acc_r     <= acc_sum_s;
                        smp_cnt_r <= smp_cnt_r + ONE_CNT;
                        state_r   <= ST_GAP;
                    end else if (tmo_done_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (avg_full_s) begin
                        avg_r       <= acc_r[AccW-1:Log2Avg];
                        avg_valid_r <= 1'b1;
                        acc_r       <= {AccW{1'b0}};
                        smp_cnt_r   <= {CntW{1'b0}};
                    end
                    if (ivl_done_s) begin
                        if (enable_i) begin
                            state_r <= ST_START;
                            start_r <= 1'b1;
                        end else begin
                            // Leaving for IDLE drops any partial average.
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                            acc_r     <= {AccW{1'b0}};
                            smp_cnt_r <= {CntW{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign start_o     = start_r;
    assign avg_o       = avg_r;
    assign avg_valid_o = avg_valid_r;
    assign busy_o      = busy_r;
    assign timeout_o   = timeout_r;

endmodule

// File: doc/sar_avg_sequencer.md
Name: sar_avg_sequencer

Overview:
- Drives the SAR conversion FSM from its downstream side.
- Issues periodic one-cycle start pulses and captures each result when end-of-conversion rises.
- Accumulates 2^Log2Avg results and emits their truncated mean with a one-cycle valid strobe.
- Flags conversions whose end-of-conversion never arrives (timeout).

Parameters:
- Width, 6, SAR result width in bits.
- Log2Avg, 2, log2 of the number of samples averaged per output (0..4; 0 = pass-through).
- IntervalW, 8, width of the start-interval counter.
- TimeoutCycles, 64, cycles to wait for end-of-conversion before aborting.

Ports:
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  run request; sampled in IDLE and at each interval boundary.
- interval_i  in  IntervalW  cycles from one start pulse to the next; 0 is treated as 1.
- eoc_i  in  1  end-of-conversion from the SAR FSM.
- result_i  in  Width  SAR result; valid when eoc_i is high.
- start_o  out  1  one-cycle start pulse to the SAR FSM.
- avg_o  out  Width  averaged result; held between updates.
- avg_valid_o  out  1  one-cycle strobe when avg_o updates.
- busy_o  out  1  high in any state except IDLE.
- timeout_o  out  1  sticky error flag; cleared only by rst_i or by enable_i=0 while in IDLE.

Behaviour:
- Reset values: start_o=0, avg_o=0, avg_valid_o=0, busy_o=0, timeout_o=0. Reset also clears the accumulator, sample count, interval counter, timeout counter and eoc edge register, and forces state IDLE. Reset mid-conversion aborts immediately with no partial output.
- eoc_i is registered once (eoc_q). Rising edge is eoc_i & ~eoc_q.
- States and transitions:
  - IDLE: busy_o=0. If enable_i=1, go to START next cycle.
  - START: start_o=1 for exactly this cycle; load the timeout counter; go to WAIT.
  - WAIT: on an eoc rising edge, add zero-extended result_i to the accumulator, increment the sample count, go to GAP. If the timeout counter reaches TimeoutCycles first: set timeout_o, leave the accumulator and count untouched, go to GAP. An eoc rising edge in the same cycle the timeout expires counts as success.
  - GAP: the interval counter runs from the START cycle. When it reaches max(interval_i,1)-1 cycles elapsed since START, go to START if enable_i=1, else to IDLE. If the conversion finishes after the interval has already elapsed, the next START follows the cycle after capture.
- Accumulator width is Width+Log2Avg, so it cannot overflow.
- When the sample count reaches 2^Log2Avg:
  - on the cycle after the capture, avg_o = acc[Width+Log2Avg-1:Log2Avg] (truncating, no rounding) and avg_valid_o=1 for one cycle;
  - the accumulator and count clear in the same cycle;
  - latency from the last eoc rising edge to avg_valid_o is 2 clocks.
- Dropping enable_i mid-sequence: the current conversion completes and is captured, then the block returns to IDLE. The partial accumulator is discarded when leaving GAP for IDLE.
- interval_i is sampled at START. Changes take effect on the next period.
- eoc_i held high across START must not be counted as a new edge.

Test Plan:
- Log2Avg=2, interval_i=20; model SAR returns 10,11,12,13 with eoc 8 cycles after each start -> start_o pulses every 20 cycles, avg_o=11 with one avg_valid_o, 2 clocks after the 4th eoc edge.
- Log2Avg=0, results 63 then 0 -> avg_o=63 then 0, one strobe per conversion, no overflow.
- eoc_i never asserts, TimeoutCycles=64 -> timeout_o set 64 cycles after start_o, next start_o follows per interval, no avg_valid_o.
- interval_i=3 with conversion taking 8 cycles -> next start_o arrives the cycle after capture; start pulses never overlap a conversion.
- enable_i dropped after the 2nd of 4 samples -> 3rd conversion is captured, block enters IDLE with busy_o=0 and no strobe; re-enable starts a fresh 4-sample average.
- rst_i asserted in WAIT -> next cycle all outputs are 0 and state is IDLE; a later eoc pulse produces no capture.
